// File: rtl/ir_mem_pkg.sv
// Shared types and defaults for the impulse-response memory path
// (arbiter, recorder and convolution engine).
package ir_mem_pkg;

   localparam int DEF_ADDR_W       = 16;
   localparam int DEF_DATA_W       = 16;
   localparam int DEF_IR_LENGTH    = 24000;
   localparam int DEF_BURST_LEN    = 8;
   localparam int DEF_STARVE_LIMIT = 64;
   localparam int IDX_W            = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      BURST = 2'd2,
      DRAIN = 2'd3
   } arb_state_t;

   function automatic logic addr_out_of_range(input logic [31:0] addr,
                                              input int unsigned ir_length);
      return addr >= ir_length;
   endfunction

endpackage

// File: rtl/ir_mem_arbiter_if.sv
// Requester and BRAM-side signals of the IR memory arbiter.
// slave = arbiter side, master = requesters/memory side.
interface ir_mem_arbiter_if
   import ir_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_grant;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_base;
   logic              rd_grant;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic [IDX_W-1:0]  rd_index;
   logic              rd_done;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;
   logic              bad_addr;

   modport slave (
      input  wr_req, wr_addr, wr_data, rd_req, rd_base, mem_rdata,
      output wr_grant, rd_grant, rd_valid, rd_data, rd_index, rd_done,
             mem_addr, mem_we, mem_wdata, busy, bad_addr
   );

   modport master (
      output wr_req, wr_addr, wr_data, rd_req, rd_base, mem_rdata,
      input  wr_grant, rd_grant, rd_valid, rd_data, rd_index, rd_done,
             mem_addr, mem_we, mem_wdata, busy, bad_addr
   );

endinterface

// File: rtl/ir_addr_wrap.sv
// Burst address counter: loads a base, steps modulo IR_LENGTH, and
// down-counts the remaining taps to a terminal count.
module ir_addr_wrap
   import ir_mem_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int IR_LENGTH = DEF_IR_LENGTH,
   parameter int BURST_LEN = DEF_BURST_LEN,
   parameter int CNT_W     = 3
) (
   input  logic              audio_clk,
   input  logic              rst_in_n,
   input  logic              i_load,
   input  logic              i_step,
   input  logic [ADDR_W-1:0] i_base,
   output logic [ADDR_W-1:0] o_next,
   output logic [CNT_W-1:0]  o_left,
   output logic              o_tc
);

   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_left;
   logic [ADDR_W-1:0] w_next;

   assign w_next = (r_addr == ADDR_W'(IR_LENGTH - 1)) ? '0 : r_addr + 1'b1;

   always_ff @(posedge audio_clk) begin
      if (!rst_in_n) begin
         r_addr <= '0;
         r_left <= '0;
      end else if (i_load) begin
         r_addr <= i_base;
         r_left <= CNT_W'(BURST_LEN - 1);
      end else if (i_step && (r_left != '0)) begin
         r_addr <= w_next;
         r_left <= r_left - 1'b1;
      end
   end

   assign o_next = w_next;
   assign o_left = r_left;
   assign o_tc   = (r_left == '0);

endmodule

// File: rtl/ir_mem_arbiter.sv
// Single-port IR memory arbiter: single-word writes vs atomic 8-tap read
// bursts, write priority with bounded reader starvation, sticky range flag.
//
// state | meaning
// IDLE  | arbitrate between writer and reader
// WRITE | one-cycle write slot, wr_grant pulsed
// BURST | issuing burst addresses (or one dead cycle for a bad base)
// DRAIN | last tap presented, rd_done pulsed
module ir_mem_arbiter
   import ir_mem_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int IR_LENGTH    = DEF_IR_LENGTH,
   parameter int BURST_LEN    = DEF_BURST_LEN,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic            audio_clk,
   input  logic            rst_in_n,
   ir_mem_arbiter_if.slave bus
);

   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

   arb_state_t        r_state;
   logic              r_wr_grant;
   logic              r_rd_grant;
   logic              r_rd_valid;
   logic              r_rd_done;
   logic              r_mem_we;
   logic              r_bad_addr;
   logic              r_bad_burst;
   logic [IDX_W-1:0]  r_rd_index;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [SC_W-1:0]   r_starve_cnt;

   logic              w_starved;
   logic              w_sel_wr;
   logic              w_sel_rd;
   logic              w_wr_bad;
   logic              w_rd_bad;
   logic              w_load;
   logic              w_step;
   logic              w_tc;
   logic [ADDR_W-1:0] w_next_addr;
   logic [CNT_W-1:0]  w_left;
   logic [IDX_W-1:0]  w_beat_idx;

   assign w_starved  = (r_starve_cnt == SC_W'(STARVE_LIMIT));
   assign w_sel_wr   = bus.wr_req && !(bus.rd_req && w_starved);
   assign w_sel_rd   = bus.rd_req && !w_sel_wr;
   assign w_wr_bad   = addr_out_of_range(32'(bus.wr_addr), IR_LENGTH);
   assign w_rd_bad   = addr_out_of_range(32'(bus.rd_base), IR_LENGTH);
   assign w_load     = (r_state == IDLE) && w_sel_rd && !w_rd_bad;
   assign w_step     = (r_state == BURST) && !r_bad_burst && !w_tc;
   assign w_beat_idx = IDX_W'(BURST_LEN - 1) - IDX_W'(w_left);

   ir_addr_wrap #(
      .ADDR_W    (ADDR_W),
      .IR_LENGTH (IR_LENGTH),
      .BURST_LEN (BURST_LEN),
      .CNT_W     (CNT_W)
   ) u_addr_wrap (
      .audio_clk (audio_clk),
      .rst_in_n  (rst_in_n),
      .i_load    (w_load),
      .i_step    (w_step),
      .i_base    (bus.rd_base),
      .o_next    (w_next_addr),
      .o_left    (w_left),
      .o_tc      (w_tc)
   );

   always_ff @(posedge audio_clk) begin
      if (!rst_in_n) begin
         r_state      <= IDLE;
         r_wr_grant   <= 1'b0;
         r_rd_grant   <= 1'b0;
         r_rd_valid   <= 1'b0;
         r_rd_done    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_bad_addr   <= 1'b0;
         r_bad_burst  <= 1'b0;
         r_rd_index   <= '0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_starve_cnt <= '0;
      end else begin
         r_wr_grant <= 1'b0;
         r_rd_grant <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_done  <= 1'b0;
         r_mem_we   <= 1'b0;
         // A reader that is not asking cannot be starved
         if (!bus.rd_req) r_starve_cnt <= '0;
         case (r_state)
            IDLE: begin
               if (w_sel_wr) begin
                  r_state     <= WRITE;
                  r_wr_grant  <= 1'b1;
                  r_mem_addr  <= bus.wr_addr;
                  r_mem_wdata <= bus.wr_data;
                  if (w_wr_bad) r_bad_addr <= 1'b1;
                  else          r_mem_we   <= 1'b1;
                  if (bus.rd_req && !w_starved) r_starve_cnt <= r_starve_cnt + 1'b1;
               end else if (w_sel_rd) begin
                  r_state      <= BURST;
                  r_rd_grant   <= 1'b1;
                  r_starve_cnt <= '0;
                  r_bad_burst  <= w_rd_bad;
                  if (w_rd_bad) r_bad_addr <= 1'b1;
                  else          r_mem_addr <= bus.rd_base;
               end
            end
            WRITE: r_state <= IDLE;
            BURST: begin
               if (r_bad_burst) begin
                  r_state   <= DRAIN;
                  r_rd_done <= 1'b1;
               end else begin
                  r_rd_valid <= 1'b1;
                  r_rd_index <= w_beat_idx;
                  if (w_tc) begin
                     r_state   <= DRAIN;
                     r_rd_done <= 1'b1;
                  end else begin
                     r_mem_addr <= w_next_addr;
                  end
               end
            end
            DRAIN: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.wr_grant  = r_wr_grant;
   assign bus.rd_grant  = r_rd_grant;
   assign bus.rd_valid  = r_rd_valid;
   assign bus.rd_data   = r_rd_valid ? bus.mem_rdata : '0;
   assign bus.rd_index  = r_rd_index;
   assign bus.rd_done   = r_rd_done;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.busy      = (r_state != IDLE);
   assign bus.bad_addr  = r_bad_addr;

endmodule

// File: tb/tb_ir_mem_arbiter.sv
// Bench for ir_mem_arbiter: directed and randomized writes/bursts checked
// against an array-based memory model and a grant-pattern model.
module tb_ir_mem_arbiter;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam int IR_LEN = 24000;
   localparam int BLEN   = 8;
   localparam int SLIM   = 4;

   logic audio_clk = 1'b0;
   logic rst_in_n  = 1'b0;
   int   n_checks  = 0;
   int   n_errors  = 0;
   logic exp_bad   = 1'b0;

   logic [DATA_W-1:0] bram    [0:65535];
   logic [DATA_W-1:0] ref_mem [0:65535];

   ir_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ir_mem_arbiter #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .IR_LENGTH    (IR_LEN),
      .BURST_LEN    (BLEN),
      .STARVE_LIMIT (SLIM)
   ) dut (
      .audio_clk (audio_clk),
      .rst_in_n  (rst_in_n),
      .bus       (bus)
   );

   always #5 audio_clk = ~audio_clk;

   // BRAM: write-first not required, 1-cycle read latency
   always @(posedge audio_clk) begin
      if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= bram[bus.mem_addr];
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge audio_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int wrap_add(input int base, input int i);
      return (base + i) % IR_LEN;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wr_grant"},  32'(bus.wr_grant),  0);
      chk({tag, "_rd_grant"},  32'(bus.rd_grant),  0);
      chk({tag, "_rd_valid"},  32'(bus.rd_valid),  0);
      chk({tag, "_rd_data"},   32'(bus.rd_data),   0);
      chk({tag, "_rd_index"},  32'(bus.rd_index),  0);
      chk({tag, "_rd_done"},   32'(bus.rd_done),   0);
      chk({tag, "_mem_addr"},  32'(bus.mem_addr),  0);
      chk({tag, "_mem_we"},    32'(bus.mem_we),    0);
      chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
      chk({tag, "_busy"},      32'(bus.busy),      0);
      chk({tag, "_bad_addr"},  32'(bus.bad_addr),  0);
   endtask

   // Caller guarantees the arbiter is idle and no read is pending
   task automatic do_write(input int a, input logic [DATA_W-1:0] d);
      bus.wr_req  = 1'b1;
      bus.wr_addr = ADDR_W'(a);
      bus.wr_data = d;
      tick();
      chk("wr_grant", 32'(bus.wr_grant), 1);
      if (a >= IR_LEN) begin
         exp_bad = 1'b1;
         chk("wr_we_oob", 32'(bus.mem_we), 0);
      end else begin
         chk("wr_we",    32'(bus.mem_we),    1);
         chk("wr_addr",  32'(bus.mem_addr),  32'(a));
         chk("wr_wdata", 32'(bus.mem_wdata), 32'(d));
         ref_mem[a] = d;
      end
      chk("wr_busy",  32'(bus.busy),     1);
      chk("wr_bad",   32'(bus.bad_addr), 32'(exp_bad));
      bus.wr_req = 1'b0;
      tick();
      chk("wr_idle",       32'(bus.busy),     0);
      chk("wr_grant_once", 32'(bus.wr_grant), 0);
      chk("wr_we_once",    32'(bus.mem_we),   0);
   endtask

   task automatic do_burst(input int base);
      bus.rd_req  = 1'b1;
      bus.rd_base = ADDR_W'(base);
      tick();
      chk("rd_grant",      32'(bus.rd_grant), 1);
      chk("rd_busy",       32'(bus.busy),     1);
      chk("rd_valid_pre",  32'(bus.rd_valid), 0);
      bus.rd_req = 1'b0;
      if (base >= IR_LEN) begin
         exp_bad = 1'b1;
         chk("rd_bad", 32'(bus.bad_addr), 1);
         tick();
         chk("rd_oob_done",  32'(bus.rd_done),  1);
         chk("rd_oob_valid", 32'(bus.rd_valid), 0);
         tick();
         chk("rd_oob_done_once", 32'(bus.rd_done),  0);
         chk("rd_oob_valid2",    32'(bus.rd_valid), 0);
         chk("rd_oob_idle",      32'(bus.busy),     0);
      end else begin
         chk("rd_addr0", 32'(bus.mem_addr), 32'(base));
         chk("rd_bad",   32'(bus.bad_addr), 32'(exp_bad));
         for (int i = 0; i < BLEN; i++) begin
            tick();
            chk("rd_valid", 32'(bus.rd_valid), 1);
            chk("rd_index", 32'(bus.rd_index), 32'(i));
            chk("rd_data",  32'(bus.rd_data),  32'(ref_mem[wrap_add(base, i)]));
            chk("rd_done",  32'(bus.rd_done),  (i == BLEN - 1) ? 1 : 0);
            if (i < BLEN - 1) chk("rd_addr", 32'(bus.mem_addr), 32'(wrap_add(base, i + 1)));
         end
         tick();
         chk("rd_valid_post", 32'(bus.rd_valid), 0);
         chk("rd_done_post",  32'(bus.rd_done),  0);
         chk("rd_idle",       32'(bus.busy),     0);
      end
   endtask

   // Returns which requester was granted next; 0 if none within the bound
   task automatic wait_grant(output byte who);
      who = 8'd0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (bus.wr_grant) begin
            who = "W";
            ref_mem[int'(bus.wr_addr)] = bus.wr_data;
            bus.wr_data = DATA_W'($urandom);
            break;
         end
         if (bus.rd_grant) begin
            who = "R";
            break;
         end
      end
   endtask

   initial begin
      byte who;
      byte exp_who;
      int  a;
      int  b;
      logic [DATA_W-1:0] d;

      for (int i = 0; i < 65536; i++) begin
         bram[i]    = DATA_W'(i);
         ref_mem[i] = DATA_W'(i);
      end
      bus.wr_req  = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.rd_req  = 1'b0;
      bus.rd_base = '0;

      rst_in_n = 1'b0;
      tick();
      tick();
      chk_all_zero("reset");
      rst_in_n = 1'b1;
      tick();

      do_write(5, 16'h1234);
      do_burst(100);
      do_burst(23996);
      do_burst(0);

      for (int n = 0; n < 12; n++) begin
         a = int'($urandom_range(0, IR_LEN - 1));
         d = DATA_W'($urandom);
         do_write(a, d);
         b = (a + IR_LEN - int'($urandom_range(0, BLEN - 1))) % IR_LEN;
         do_burst(b);
         if (n % 4 == 0) do_burst(int'($urandom_range(IR_LEN - BLEN, IR_LEN - 1)));
      end

      // Both requesters held: every STARVE_LIMIT writes, one burst
      bus.wr_addr = 16'd1000;
      bus.wr_data = DATA_W'($urandom);
      bus.rd_base = 16'd200;
      bus.wr_req  = 1'b1;
      bus.rd_req  = 1'b1;
      for (int k = 0; k < 3 * (SLIM + 1); k++) begin
         wait_grant(who);
         exp_who = (k % (SLIM + 1) == SLIM) ? 8'h52 : 8'h57;
         chk("contend_order", 32'(who), 32'(exp_who));
      end
      wait_grant(who);
      chk("contend_pre1", 32'(who), 32'h57);
      wait_grant(who);
      chk("contend_pre2", 32'(who), 32'h57);
      bus.rd_req = 1'b0;
      wait_grant(who);
      chk("contend_rd_low", 32'(who), 32'h57);
      bus.rd_req = 1'b1;
      for (int k = 0; k <= SLIM; k++) begin
         wait_grant(who);
         exp_who = (k == SLIM) ? 8'h52 : 8'h57;
         chk("starve_cleared", 32'(who), 32'(exp_who));
      end
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (!bus.busy) break;
         tick();
      end
      chk("contend_drain_idle", 32'(bus.busy), 0);
      do_burst(996);

      do_write(24000, 16'hBEEF);
      do_burst(30000);
      do_write(10, 16'h0A0A);
      do_burst(4);

      // Reset at the 4th beat of a burst
      bus.rd_req  = 1'b1;
      bus.rd_base = 16'd300;
      tick();
      chk("rst_burst_grant", 32'(bus.rd_grant), 1);
      bus.rd_req = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("rst_burst_beat3", 32'(bus.rd_index), 3);
      rst_in_n = 1'b0;
      tick();
      chk_all_zero("midburst_rst");
      exp_bad  = 1'b0;
      rst_in_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         chk("post_rst_valid", 32'(bus.rd_valid), 0);
         chk("post_rst_done",  32'(bus.rd_done),  0);
      end
      do_write(7, DATA_W'($urandom));
      do_burst(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ir_mem_arbiter.md
# ir_mem_arbiter

Arbitrates the single-port impulse-response memory between the impulse recorder (single-word writes) and the convolution engine (8-tap read bursts). Sits between those two requesters and the IR BRAM in the audio_clk domain. Makes bursts atomic, gives writes default priority, and bounds reader starvation. Also flags out-of-range addresses.

## Interface
Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 16, sample width (signed, passed through untouched)
- IR_LENGTH, 24000, valid address range 0..IR_LENGTH-1; burst addresses wrap modulo IR_LENGTH
- BURST_LEN, 8, taps per read burst
- STARVE_LIMIT, 64, consecutive write grants tolerated while rd_req is pending

Ports:
- audio_clk  in  1  sole clock
- rst_in_n  in  1  reset, synchronous, active-low
- wr_req  in  1  write request; held with wr_addr/wr_data until wr_grant
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_grant  out  1  1-cycle pulse: write accepted
- rd_req  in  1  burst request; held with rd_base until rd_grant
- rd_base  in  ADDR_W  first tap address
- rd_grant  out  1  1-cycle pulse: burst accepted
- rd_valid  out  1  rd_data/rd_index valid
- rd_data  out  DATA_W  tap data
- rd_index  out  3  tap number within the burst, 0..BURST_LEN-1
- rd_done  out  1  1-cycle pulse: burst finished
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, 1-cycle latency
- busy  out  1  state is not IDLE
- bad_addr  out  1  sticky out-of-range flag; cleared only by reset

## Operation
- FSM states: IDLE, WRITE, BURST, DRAIN.
- IDLE → WRITE when the write is selected; IDLE → BURST when the read is selected; otherwise stay in IDLE.
- Arbitration happens only in IDLE. If only one request is high, that requester wins.
- If both are high, the writer wins unless starve_cnt == STARVE_LIMIT, in which case the reader wins.
- starve_cnt increments on each write grant while rd_req is high. It clears on a read grant or whenever rd_req is low. It saturates at STARVE_LIMIT.
- WRITE state (one cycle):
  - drive mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, and pulse wr_grant;
  - then return to IDLE.
- WRITE with wr_addr ≥ IR_LENGTH: still pulse wr_grant, but keep mem_we=0 and set bad_addr.
- BURST state:
  - capture rd_base and pulse rd_grant on entry;
  - issue mem_addr = (base+i) mod IR_LENGTH for i = 0..BURST_LEN-1 on consecutive cycles;
  - then go to DRAIN.
- DRAIN state (one cycle): present the last tap and pulse rd_done, then go to IDLE.
- Each read beat appears one cycle after its address: rd_valid=1, rd_data=mem_rdata, rd_index=i.
- rd_done coincides with the beat rd_index=BURST_LEN-1.
- rd_base ≥ IR_LENGTH:
  - pulse rd_grant and set bad_addr;
  - issue no memory reads and produce no rd_valid;
  - pulse rd_done the following cycle, then return to IDLE.
- Bursts are atomic. A write request arriving mid-burst waits until IDLE.
- mem_addr holds its last value while idle.

## Timing
- Write: selected at cycle N. At N+1: wr_grant, mem_we and the address/data are all driven. Arbiter is back in IDLE at N+2. Peak rate is one write per 2 cycles.
- Read: selected at cycle N.
  - rd_grant at N+1.
  - Addresses on N+1..N+8.
  - rd_valid on N+2..N+9.
  - rd_done at N+9.
  - Next arbitration at N+10.
- Requesters may change req/addr/data on the cycle after their grant pulse.
- Reset: every output goes to 0 (including mem_addr, bad_addr and busy) on the first edge with rst_in_n=0; state goes to IDLE and starve_cnt to 0.
- Reset mid-burst abandons the burst. No rd_done is produced, and no further rd_valid appears after the reset edge.
- Wrap example: base=23996 gives addresses 23996..23999 then 0..3.

## Structure
- Package ir_mem_pkg holds: the state enum (IDLE, WRITE, BURST, DRAIN), default IR_LENGTH, ADDR_W, DATA_W and BURST_LEN.
- The convolution and recording blocks import the same package.
- One sub-module, ir_addr_wrap: a loadable burst address counter with modulo-IR_LENGTH wrap and a terminal-count output.

## Test plan
- Single write: wr_req with addr 5, data 0x1234 → wr_grant and mem_we with addr 5 and data 0x1234 at N+1; busy low at N+2.
- Single burst: rd_base=100, memory preloaded with mem[a]=a → rd_valid with data 100..107 and index 0..7 on N+2..N+9; rd_done at N+9.
- Wrap: rd_base=23996 → data 23996, 23997, 23998, 23999, 0, 1, 2, 3.
- Contention: both req held continuously, STARVE_LIMIT=4 → grant pattern of 4 writes then 1 burst, repeating; starve_cnt clears when rd_req drops.
- Out of range: wr_addr=24000 → wr_grant with mem_we=0; rd_base=30000 → rd_grant, no rd_valid, rd_done one cycle later; bad_addr stays 1 until reset.
- Reset at the 4th beat of a burst → outputs 0 on the next edge, no rd_done; a new write is accepted afterwards.
